// File: rtl/gray_pkg.sv
// Shared types and Gray/binary helpers for the parametrised Gray counter.
// Helpers operate on a fixed-width word; callers zero-extend and truncate.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  // Prefix XOR from the MSB down; leading zeros from extension are harmless.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational WIDTH-bit Gray-to-binary converter, used on the load path.
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(gray_word_t'(gray)));

endmodule

// File: rtl/gray_counter_param.sv
// Bidirectional WIDTH-bit Gray sequence generator with clear, load,
// wrap/saturate ends, terminal count and a registered wrap pulse.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_gray_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             tc_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] load_bin;
  logic             wrap_q, wrap_d;
  dir_t             dir;

  assign dir = dir_t'(up_i);

  gray2bin_conv #(.WIDTH(WIDTH)) u_load_conv (
    .gray (load_gray_i),
    .bin  (load_bin)
  );

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    bin_d  = bin_q;
    gray_d = gray_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      bin_d  = '0;
      gray_d = '0;
    end else if (load_i) begin
      bin_d  = load_bin;
      gray_d = load_gray_i;
    end else if (en_i) begin
      unique case (dir)
        DIR_UP: begin
          if (bin_q != MAX) begin
            bin_d = bin_q + WIDTH'(1);
          end else if (WRAP) begin
            bin_d  = '0;
            wrap_d = 1'b1;
          end
        end
        DIR_DOWN: begin
          if (bin_q != '0) begin
            bin_d = bin_q - WIDTH'(1);
          end else if (WRAP) begin
            bin_d  = MAX;
            wrap_d = 1'b1;
          end
        end
        default: bin_d = bin_q;
      endcase
      gray_d = WIDTH'(bin2gray(gray_word_t'(bin_d)));
    end
  end

  // NOTE: rst_n is sampled only at the clock edge, making the reset
  // synchronous; state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign gray_o = gray_q;
  assign bin_o  = bin_q;
  assign wrap_o = wrap_q;

  // Terminal count tracks the requested direction even while disabled.
  assign tc_o = (up_i && (bin_q == MAX)) || (!up_i && (bin_q == '0));

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench: three counter configurations driven by directed vectors,
// expected results queued at issue time and compared by a separate monitor.
module tb_gray_counter_param;

  typedef struct packed {
    logic [3:0] gray;
    logic [3:0] bin;
    logic       wrap;
    logic       tc;
    logic       step;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a [3];
  logic       clr_a [3];
  logic       ld_a  [3];
  logic [3:0] lg_a  [3];
  logic       en_a  [3];
  logic       up_a  [3];

  logic [2:0] g0, b0, g2, b2;
  logic [3:0] g1, b1;
  logic       tc0, tc1, tc2, w0, w1, w2;

  logic [3:0] gray_a [3];
  logic [3:0] bin_a  [3];
  logic       wrap_a [3];
  logic       tc_a   [3];

  assign gray_a[0] = {1'b0, g0};
  assign gray_a[1] = g1;
  assign gray_a[2] = {1'b0, g2};
  assign bin_a[0]  = {1'b0, b0};
  assign bin_a[1]  = b1;
  assign bin_a[2]  = {1'b0, b2};
  assign wrap_a[0] = w0;
  assign wrap_a[1] = w1;
  assign wrap_a[2] = w2;
  assign tc_a[0]   = tc0;
  assign tc_a[1]   = tc1;
  assign tc_a[2]   = tc2;

  gray_counter_param #(.WIDTH(3), .WRAP(1'b1)) dut_w3wrap (
    .clk(clk), .rst_n(rst_a[0]), .clr_i(clr_a[0]), .load_i(ld_a[0]),
    .load_gray_i(lg_a[0][2:0]), .en_i(en_a[0]), .up_i(up_a[0]),
    .gray_o(g0), .bin_o(b0), .tc_o(tc0), .wrap_o(w0)
  );

  gray_counter_param #(.WIDTH(4), .WRAP(1'b1)) dut_w4wrap (
    .clk(clk), .rst_n(rst_a[1]), .clr_i(clr_a[1]), .load_i(ld_a[1]),
    .load_gray_i(lg_a[1]), .en_i(en_a[1]), .up_i(up_a[1]),
    .gray_o(g1), .bin_o(b1), .tc_o(tc1), .wrap_o(w1)
  );

  gray_counter_param #(.WIDTH(3), .WRAP(1'b0)) dut_w3sat (
    .clk(clk), .rst_n(rst_a[2]), .clr_i(clr_a[2]), .load_i(ld_a[2]),
    .load_gray_i(lg_a[2][2:0]), .en_i(en_a[2]), .up_i(up_a[2]),
    .gray_o(g2), .bin_o(b2), .tc_o(tc2), .wrap_o(w2)
  );

  exp_t  q0[$];
  exp_t  q1[$];
  exp_t  q2[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    seq    [3] = '{0, 0, 0};
  logic [3:0] prev_g [3] = '{4'h0, 4'h0, 4'h0};
  string dut_name [3] = '{"w3wrap", "w4wrap", "w3sat"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic score(input int id, input exp_t e);
    string n;
    n = $sformatf("%s#%0d", dut_name[id], seq[id]);
    check({n, ".gray"}, 32'(gray_a[id]), 32'(e.gray));
    check({n, ".bin"},  32'(bin_a[id]),  32'(e.bin));
    check({n, ".wrap"}, 32'(wrap_a[id]), 32'(e.wrap));
    check({n, ".tc"},   32'(tc_a[id]),   32'(e.tc));
    if (e.step) check({n, ".onebit"}, 32'($countones(prev_g[id] ^ gray_a[id])), 32'd1);
    prev_g[id] = gray_a[id];
    seq[id]++;
  endtask

  // Monitor: results of an edge are sampled 1 time unit after it.
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) score(0, q0.pop_front());
    if (q1.size() > 0) score(1, q1.pop_front());
    if (q2.size() > 0) score(2, q2.pop_front());
  end

  task automatic vec(input int id, input logic rst, input logic clr, input logic ld,
                     input logic [3:0] lg, input logic en, input logic up,
                     input logic [3:0] eg, input logic [3:0] eb,
                     input logic ew, input logic etc, input logic es);
    exp_t e;
    @(negedge clk);
    rst_a[id] = rst;
    clr_a[id] = clr;
    ld_a[id]  = ld;
    lg_a[id]  = lg;
    en_a[id]  = en;
    up_a[id]  = up;
    e = '{gray: eg, bin: eb, wrap: ew, tc: etc, step: es};
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b0; clr_a[i] = 1'b0; ld_a[i] = 1'b0;
      lg_a[i] = 4'h0;  en_a[i] = 1'b0;  up_a[i] = 1'b1;
    end

    // WIDTH=3 wrap: reset hold with en high, full forward lap plus one.
    //      id rst clr ld lg      en up  gray     bin      w  tc step
    vec(0, 0, 0, 0, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, 0);
    vec(0, 0, 0, 0, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, 0);
    vec(0, 1, 0, 0, 4'b0000, 1, 1, 4'b0001, 4'b0001, 0, 0, 1);
    vec(0, 1, 0, 0, 4'b0000, 1, 1, 4'b0011, 4'b0010, 0, 0, 1);
    vec(0, 1, 0, 0, 4'b0000, 1, 1, 4'b0010, 4'b0011, 0, 0, 1);
    vec(0, 1, 0, 0, 4'b0000, 1, 1, 4'b0110, 4'b0100, 0, 0, 1);
    vec(0, 1, 0, 0, 4'b0000, 1, 1, 4'b0111, 4'b0101, 0, 0, 1);
    vec(0, 1, 0, 0, 4'b0000, 1, 1, 4'b0101, 4'b0110, 0, 0, 1);
    vec(0, 1, 0, 0, 4'b0000, 1, 1, 4'b0100, 4'b0111, 0, 1, 1);
    vec(0, 1, 0, 0, 4'b0000, 1, 1, 4'b0000, 4'b0000, 1, 0, 1);
    vec(0, 1, 0, 0, 4'b0000, 1, 1, 4'b0001, 4'b0001, 0, 0, 1);
    // Priority: load over enable, clear over load, reset over everything.
    vec(0, 1, 0, 1, 4'b0110, 1, 1, 4'b0110, 4'b0100, 0, 0, 0);
    vec(0, 1, 1, 1, 4'b0110, 1, 1, 4'b0000, 4'b0000, 0, 0, 0);
    vec(0, 0, 1, 1, 4'b0110, 1, 1, 4'b0000, 4'b0000, 0, 0, 0);
    // Enable gating from 011: en 1,0,0,1.
    vec(0, 1, 0, 1, 4'b0011, 0, 1, 4'b0011, 4'b0010, 0, 0, 0);
    vec(0, 1, 0, 0, 4'b0000, 1, 1, 4'b0010, 4'b0011, 0, 0, 1);
    vec(0, 1, 0, 0, 4'b0000, 0, 1, 4'b0010, 4'b0011, 0, 0, 0);
    vec(0, 1, 0, 0, 4'b0000, 0, 1, 4'b0010, 4'b0011, 0, 0, 0);
    vec(0, 1, 0, 0, 4'b0000, 1, 1, 4'b0110, 4'b0100, 0, 0, 1);
    // tc follows up_i while disabled, then reverse wrap 000 -> 100.
    vec(0, 1, 0, 1, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 0, 0);
    vec(0, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
    vec(0, 1, 0, 0, 4'b0000, 1, 0, 4'b0100, 4'b0111, 1, 0, 1);
    vec(0, 1, 0, 0, 4'b0000, 0, 0, 4'b0100, 4'b0111, 0, 0, 0);

    // WIDTH=4 wrap: counting down from reset, then direction reversal.
    vec(1, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
    vec(1, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
    vec(1, 1, 0, 0, 4'b0000, 1, 0, 4'b1000, 4'b1111, 1, 0, 1);
    vec(1, 1, 0, 0, 4'b0000, 1, 0, 4'b1001, 4'b1110, 0, 0, 1);
    vec(1, 1, 0, 0, 4'b0000, 1, 0, 4'b1011, 4'b1101, 0, 0, 1);
    vec(1, 1, 0, 0, 4'b0000, 1, 1, 4'b1001, 4'b1110, 0, 0, 1);
    vec(1, 1, 0, 0, 4'b0000, 1, 1, 4'b1000, 4'b1111, 0, 1, 1);
    vec(1, 1, 0, 0, 4'b0000, 1, 1, 4'b0000, 4'b0000, 1, 0, 1);
    vec(1, 1, 0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 0, 0);

    // WIDTH=3 saturate: hold at both ends, no wrap pulse.
    vec(2, 0, 0, 0, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, 0);
    vec(2, 0, 0, 0, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, 0);
    vec(2, 1, 0, 1, 4'b0100, 0, 1, 4'b0100, 4'b0111, 0, 1, 0);
    vec(2, 1, 0, 0, 4'b0000, 1, 1, 4'b0100, 4'b0111, 0, 1, 0);
    vec(2, 1, 0, 0, 4'b0000, 1, 1, 4'b0100, 4'b0111, 0, 1, 0);
    vec(2, 1, 0, 0, 4'b0000, 1, 1, 4'b0100, 4'b0111, 0, 1, 0);
    vec(2, 1, 0, 0, 4'b0000, 0, 0, 4'b0100, 4'b0111, 0, 0, 0);
    vec(2, 1, 0, 0, 4'b0000, 1, 0, 4'b0101, 4'b0110, 0, 0, 1);
    vec(2, 1, 0, 1, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 1, 0);
    vec(2, 1, 0, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 1, 0);
    vec(2, 1, 0, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 1, 0);
    vec(2, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);

    repeat (3) @(negedge clk);
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);
    check("drain_q2", 32'(q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
